// File: rtl/operand_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// operand_fetch : register-read/issue stage with same-cycle writeback bypass,
//                 pending-destination scoreboard and registered output handshake
// Revision      : 1.0
// ---------------------------------------------------------------------------
module operand_fetch #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  // decoded instruction in
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [AW-1:0]     in_rs_i,
  input  logic [AW-1:0]     in_rt_i,
  input  logic [AW-1:0]     in_rd_i,
  input  logic              in_we_i,
  // register file read side
  output logic [AW-1:0]     rf_ra_o,
  output logic [AW-1:0]     rf_rb_o,
  input  logic [DW-1:0]     rf_a_i,
  input  logic [DW-1:0]     rf_b_i,
  // writeback (shared with register file write port)
  input  logic              wb_we_i,
  input  logic [AW-1:0]     wb_rw_i,
  input  logic [DW-1:0]     wb_w_i,
  // operands toward execute
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DW-1:0]     out_a_o,
  output logic [DW-1:0]     out_b_o,
  output logic [AW-1:0]     out_rd_o,
  output logic              out_we_o,
  // scoreboard observation
  output logic [2**AW-1:0]  pending_o
);

  localparam int c_NREG = 2**AW;

  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_a_q,     out_a_d;
  logic [DW-1:0]     out_b_q,     out_b_d;
  logic [AW-1:0]     out_rd_q,    out_rd_d;
  logic              out_we_q,    out_we_d;
  logic [c_NREG-1:0] pending_q,   pending_d;

  logic              wb_hit;
  logic              byp_a;
  logic              byp_b;
  logic              haz_a;
  logic              haz_b;
  logic              haz_waw;
  logic              haz;
  logic              slot_free;
  logic              accept;
  logic              rd_tracked;
  logic [DW-1:0]     op_a;
  logic [DW-1:0]     op_b;

  assign rf_ra_o = in_rs_i;
  assign rf_rb_o = in_rt_i;

  // Writes to r0 are discarded by the regfile, so they neither bypass nor clear.
  assign wb_hit = wb_we_i && (wb_rw_i != '0);
  assign byp_a  = wb_hit && (wb_rw_i == in_rs_i);
  assign byp_b  = wb_hit && (wb_rw_i == in_rt_i);

  always_comb begin
    haz_a   = pending_q[in_rs_i] && !byp_a;
    haz_b   = pending_q[in_rt_i] && !byp_b;
    // A WAW stall is not released by the arriving writeback: the slot frees a cycle later.
    haz_waw = in_we_i && (in_rd_i != '0) && pending_q[in_rd_i];
    haz     = haz_a || haz_b || haz_waw;
  end

  assign slot_free  = !out_valid_q || out_ready_i;
  assign in_ready_o = !haz && slot_free;
  assign accept     = in_valid_i && in_ready_o;
  assign rd_tracked = in_we_i && (in_rd_i != '0);

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (byp_a) begin
      op_a = wb_w_i;
    end else if (in_rs_i != '0) begin
      op_a = rf_a_i;
    end
    if (byp_b) begin
      op_b = wb_w_i;
    end else if (in_rt_i != '0) begin
      op_b = rf_b_i;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_rd_d    = out_rd_q;
    out_we_d    = out_we_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_a_d     = op_a;
      out_b_d     = op_b;
      out_rd_d    = in_rd_i;
      out_we_d    = in_we_i;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear first so that a new claim on the same register in the same cycle wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_hit) begin
      pending_d[wb_rw_i] = 1'b0;
    end
    if (accept && rd_tracked) begin
      pending_d[in_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_rd_q    <= out_rd_d;
      out_we_q    <= out_we_d;
      pending_q   <= pending_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_a_o     = out_a_q;
  assign out_b_o     = out_b_q;
  assign out_rd_o    = out_rd_q;
  assign out_we_o    = out_we_q;
  assign pending_o   = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_operand_fetch : directed checks of bypass, RAW/WAW stalls, backpressure,
//                    r0 handling and asynchronous reset of operand_fetch
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_operand_fetch;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready, in_we;
  logic [AW-1:0] in_rs, in_rt, in_rd;
  logic [AW-1:0] rf_ra, rf_rb;
  logic [DW-1:0] rf_a, rf_b;
  logic          wb_we;
  logic [AW-1:0] wb_rw;
  logic [DW-1:0] wb_w;
  logic          out_valid, out_ready, out_we;
  logic [DW-1:0] out_a, out_b;
  logic [AW-1:0] out_rd;
  logic [31:0]   pending;

  int n_cmp = 0;
  int n_err = 0;

  operand_fetch #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_rs_i    (in_rs),
    .in_rt_i    (in_rt),
    .in_rd_i    (in_rd),
    .in_we_i    (in_we),
    .rf_ra_o    (rf_ra),
    .rf_rb_o    (rf_rb),
    .rf_a_i     (rf_a),
    .rf_b_i     (rf_b),
    .wb_we_i    (wb_we),
    .wb_rw_i    (wb_rw),
    .wb_w_i     (wb_w),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_a_o    (out_a),
    .out_b_o    (out_b),
    .out_rd_o   (out_rd),
    .out_we_o   (out_we),
    .pending_o  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; comb outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_we = 1'b0;
    rf_a = '0; rf_b = '0; wb_we = 1'b0; wb_rw = '0; wb_w = '0;
    out_ready = 1'b1;
  endtask

  task automatic instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic we,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rd = rd; in_we = we;
    rf_a = a; rf_b = b;
  endtask

  task automatic wb(input logic we, input logic [AW-1:0] rw, input logic [DW-1:0] w);
    wb_we = we; wb_rw = rw; wb_w = w;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    chk("reset out_valid", out_valid, 0);
    chk("reset out_a",     out_a, 0);
    chk("reset out_rd",    out_rd, 0);
    chk("reset pending",   pending, 0);
    rst_n = 1'b1;
    tick();

    // Bypass: regfile still holds 5 for r3 while 9 is being written
    instr(5'd3, 5'd0, 5'd1, 1'b0, 32'd5, 32'd0);
    wb(1'b1, 5'd3, 32'd9);
    settle();
    chk("byp rf_ra",    rf_ra, 3);
    chk("byp in_ready", in_ready, 1);
    tick();
    idle();
    chk("byp out_valid", out_valid, 1);
    chk("byp out_a",     out_a, 9);
    chk("byp out_b",     out_b, 0);
    chk("byp pending",   pending, 0);
    tick();
    chk("byp drain", out_valid, 0);

    // RAW on r4
    instr(5'd1, 5'd2, 5'd4, 1'b1, 32'h11, 32'h22);
    tick();
    chk("raw1 out_a",  out_a, 32'h11);
    chk("raw1 out_b",  out_b, 32'h22);
    chk("raw1 out_rd", out_rd, 4);
    chk("raw1 out_we", out_we, 1);
    chk("raw1 pend4",  pending, 32'h10);
    instr(5'd4, 5'd0, 5'd5, 1'b0, 32'hDEAD, 32'h0);
    settle();
    chk("raw stall1", in_ready, 0);
    tick();
    chk("raw stall2", in_ready, 0);
    chk("raw drained", out_valid, 0);
    wb(1'b1, 5'd4, 32'h77);
    settle();
    chk("raw release", in_ready, 1);
    tick();
    idle();
    chk("raw2 out_valid", out_valid, 1);
    chk("raw2 out_a",     out_a, 32'h77);
    chk("raw2 out_rd",    out_rd, 5);
    chk("raw2 pending",   pending, 0);
    tick();

    // WAW on r6
    instr(5'd0, 5'd0, 5'd6, 1'b1, 32'h0, 32'h0);
    tick();
    chk("waw pend6", pending, 32'h40);
    instr(5'd0, 5'd0, 5'd6, 1'b1, 32'h0, 32'h0);
    settle();
    chk("waw stall", in_ready, 0);
    wb(1'b1, 5'd6, 32'h66);
    settle();
    chk("waw stall wb", in_ready, 0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    settle();
    chk("waw cleared", pending, 0);
    chk("waw release", in_ready, 1);
    tick();
    idle();
    chk("waw out_valid", out_valid, 1);
    chk("waw out_rd",    out_rd, 6);
    chk("waw pend6 again", pending, 32'h40);
    wb(1'b1, 5'd6, 32'h1);
    tick();
    idle();
    chk("waw final clear", pending, 0);

    // Backpressure
    out_ready = 1'b0;
    instr(5'd1, 5'd2, 5'd8, 1'b0, 32'hA1, 32'hB1);
    tick();
    instr(5'd1, 5'd2, 5'd9, 1'b0, 32'hA2, 32'hB2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp in_ready", in_ready, 0);
      tick();
      chk("bp out_valid", out_valid, 1);
      chk("bp out_a",     out_a, 32'hA1);
      chk("bp out_b",     out_b, 32'hB1);
      chk("bp out_rd",    out_rd, 8);
    end
    out_ready = 1'b1;
    settle();
    chk("bp release", in_ready, 1);
    tick();
    idle();
    chk("bp2 out_valid", out_valid, 1);
    chk("bp2 out_a",     out_a, 32'hA2);
    chk("bp2 out_b",     out_b, 32'hB2);
    chk("bp2 out_rd",    out_rd, 9);
    tick();

    // r0: reads zero, no bypass from r0 writes, never pending
    instr(5'd0, 5'd0, 5'd0, 1'b1, 32'h1234, 32'h5678);
    wb(1'b1, 5'd0, 32'hFFFF);
    settle();
    chk("r0 in_ready", in_ready, 1);
    tick();
    idle();
    chk("r0 out_a",   out_a, 0);
    chk("r0 out_b",   out_b, 0);
    chk("r0 out_we",  out_we, 1);
    chk("r0 pending", pending, 0);
    tick();

    // Set beats clear on the same register in the same cycle
    instr(5'd7, 5'd0, 5'd7, 1'b1, 32'h3, 32'h0);
    wb(1'b1, 5'd7, 32'h55);
    tick();
    idle();
    chk("setwin pend7", pending, 32'h80);
    chk("setwin out_a", out_a, 32'h55);

    // Asynchronous reset mid-cycle
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", out_valid, 0);
    chk("arst out_a",     out_a, 0);
    chk("arst out_we",    out_we, 0);
    chk("arst pending",   pending, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
